// File: rtl/urv_defs.sv
// urv_defs: shared definitions for the uRV execute-stage load/store unit.
//   - LDST_* : load/store width encodings carried on d_fun_i
//   - CAUSE_*: exception cause codes reported on x_exception_cause_o
//   - lsu_state_t: LSU state encoding, also exposed on the debug port
//   - helper functions for access size, misalignment and word crossing
package urv_defs;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [3:0] CAUSE_MISALIGNED_LOAD    = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_ACCESS_FAULT  = 4'd5;
  localparam logic [3:0] CAUSE_MISALIGNED_STORE   = 4'd6;
  localparam logic [3:0] CAUSE_STORE_ACCESS_FAULT = 4'd7;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_ACC1 = 2'd1,
    LSU_ACC2 = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_t;

  // Access size in bytes; unused encodings behave as byte accesses.
  function automatic logic [2:0] ldst_size(input logic [2:0] fun);
    case (fun)
      LDST_L:          return 3'd4;
      LDST_H, LDST_HU: return 3'd2;
      default:         return 3'd1;
    endcase
  endfunction

  function automatic logic ldst_misaligned(input logic [2:0] fun, input logic [1:0] off);
    case (fun)
      LDST_L:          return off != 2'b00;
      LDST_H, LDST_HU: return off[0];
      default:         return 1'b0;
    endcase
  endfunction

  // True when the access spills past byte 3 into the next word.
  function automatic logic ldst_crosses(input logic [2:0] fun, input logic [1:0] off);
    return ({1'b0, off} + ldst_size(fun)) > 3'd4;
  endfunction

endpackage

// File: rtl/urv_lsu_align.sv
// urv_lsu_align: combinational lane steering shared by both bus phases.
//   fun        : LDST_* width encoding
//   off        : effective address bits [1:0]
//   phase      : 0 = first word, 1 = following word of a split access
//   store_data : unshifted store operand
//   load_data  : {second word, first word} of captured load data
//   select     : byte enables for the current phase
//   store_lane : store data lanes for the current phase
//   load_value : zero/sign-extended load result
module urv_lsu_align
  import urv_defs::*;
(
  input  logic [2:0]  fun,
  input  logic [1:0]  off,
  input  logic        phase,
  input  logic [31:0] store_data,
  input  logic [63:0] load_data,
  output logic [3:0]  select,
  output logic [31:0] store_lane,
  output logic [31:0] load_value
);

  logic [3:0]  base_mask;
  logic [7:0]  mask;
  logic [63:0] st_shift;
  logic [31:0] ld_word;

  // The access is viewed as a 64-bit window starting at the aligned word:
  // phase 0 uses the low half, phase 1 the high half.
  always_comb begin
    case (ldst_size(fun))
      3'd4:    base_mask = 4'b1111;
      3'd2:    base_mask = 4'b0011;
      default: base_mask = 4'b0001;
    endcase
    mask       = {4'b0000, base_mask} << off;
    select     = phase ? mask[7:4] : mask[3:0];
    st_shift   = {32'h0, store_data} << {off, 3'b000};
    store_lane = phase ? st_shift[63:32] : st_shift[31:0];
    ld_word    = 32'(load_data >> {off, 3'b000});
    case (fun)
      LDST_B:  load_value = {{24{ld_word[7]}}, ld_word[7:0]};
      LDST_BU: load_value = {24'h0, ld_word[7:0]};
      LDST_H:  load_value = {{16{ld_word[15]}}, ld_word[15:0]};
      LDST_HU: load_value = {16'h0, ld_word[15:0]};
      default: load_value = ld_word;
    endcase
  end

endmodule

// File: rtl/urv_exec_lsu.sv
// urv_exec_lsu: execute-stage load/store unit for uRV.
// Computes EA = rs1 + imm, runs one or two data-memory bus transactions
// (two when a misaligned access is split across words), merges load data and
// pulses w_valid_o on completion. Misaligned accesses trap when splitting is
// disabled.
// Ports: clk_i/rst_i (sync, active high); x_stall_i/x_kill_i/x_stall_req_o
// pipeline control; d_* decoded instruction; dm_* data-memory bus;
// x_exception_* fault report; w_valid_o/w_load_value_o writeback;
// dbg_state current FSM state.
// Bus handshake: while dm_load_o or dm_store_o is high, address, data and
// byte enables stay constant; the cycle in which dm_ack_i is high completes
// the request and, for loads, dm_data_l_i is valid in that same cycle.
// Optional build macro URV_LSU_BUS_TIMEOUT_EN: abandon a request after
// g_timeout_cycles cycles without ack and report an access fault.
module urv_exec_lsu
  import urv_defs::*;
#(
  parameter int g_addr_width       = 32,
  parameter int g_misaligned_split = 0,
  parameter int g_timeout_cycles   = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    x_stall_i,
  input  logic                    x_kill_i,
  output logic                    x_stall_req_o,
  input  logic                    d_valid_i,
  input  logic                    d_is_load_i,
  input  logic                    d_is_store_i,
  input  logic [2:0]              d_fun_i,
  input  logic [31:0]             d_rs1_i,
  input  logic [31:0]             d_rs2_i,
  input  logic [31:0]             d_imm_i,
  output logic [g_addr_width-1:0] dm_addr_o,
  output logic [31:0]             dm_data_s_o,
  output logic [3:0]              dm_data_select_o,
  output logic                    dm_load_o,
  output logic                    dm_store_o,
  input  logic                    dm_ack_i,
  input  logic [31:0]             dm_data_l_i,
  output logic                    x_exception_o,
  output logic [3:0]              x_exception_cause_o,
  output logic [g_addr_width-1:0] x_badaddr_o,
  output logic                    w_valid_o,
  output logic [31:0]             w_load_value_o,
  output lsu_state_t              dbg_state
);

  localparam int AW = g_addr_width;

  lsu_state_t  state, state_next;
  logic [31:0] ea_full;
  logic [AW-1:0] ea, ea_r, word_addr;
  logic [2:0]  fun_r;
  logic        store_r;
  logic [31:0] rs2_r, lo_r;
  logic        is_mem, misaligned, trap, accept;
  logic        in_acc, phase2, crosses_r, ack_ok, timed_out, fault_r;
  logic [3:0]  sel;
  logic [31:0] st_lane, ld_value;

  assign ea_full    = d_rs1_i + d_imm_i;
  assign ea         = ea_full[AW-1:0];
  assign is_mem     = d_is_load_i | d_is_store_i;
  assign misaligned = ldst_misaligned(d_fun_i, ea[1:0]) && (g_misaligned_split == 0);
  assign trap   = (state == LSU_IDLE) && d_valid_i && is_mem && !x_kill_i && misaligned;
  assign accept = (state == LSU_IDLE) && d_valid_i && is_mem && !x_kill_i && !x_stall_i &&
                  !misaligned;

  assign in_acc    = (state == LSU_ACC1) || (state == LSU_ACC2);
  assign phase2    = (state == LSU_ACC2);
  assign crosses_r = ldst_crosses(fun_r, ea_r[1:0]);
  assign ack_ok    = in_acc && dm_ack_i && !timed_out;
  assign word_addr = {ea_r[AW-1:2], 2'b00};
  assign dbg_state = state;

  urv_lsu_align u_align (
    .fun        (fun_r),
    .off        (ea_r[1:0]),
    .phase      (phase2),
    .store_data (rs2_r),
    .load_data  (phase2 ? {dm_data_l_i, lo_r} : {32'h0, dm_data_l_i}),
    .select     (sel),
    .store_lane (st_lane),
    .load_value (ld_value)
  );

  always_comb begin
    state_next          = state;
    x_stall_req_o       = 1'b0;
    dm_addr_o           = '0;
    dm_data_s_o         = '0;
    dm_data_select_o    = '0;
    dm_load_o           = 1'b0;
    dm_store_o          = 1'b0;
    x_exception_o       = 1'b0;
    x_exception_cause_o = '0;
    x_badaddr_o         = '0;
    w_valid_o           = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (accept) begin
          state_next    = LSU_ACC1;
          x_stall_req_o = 1'b1;
        end
        if (trap) begin
          x_exception_o       = 1'b1;
          x_exception_cause_o = d_is_store_i ? CAUSE_MISALIGNED_STORE : CAUSE_MISALIGNED_LOAD;
          x_badaddr_o         = ea;
        end
      end
      LSU_ACC1, LSU_ACC2: begin
        x_stall_req_o    = 1'b1;
        // Second phase wraps naturally in AW bits.
        dm_addr_o        = phase2 ? word_addr + AW'(4) : word_addr;
        dm_data_s_o      = st_lane;
        dm_data_select_o = sel;
        dm_load_o        = !store_r && !timed_out;
        dm_store_o       = store_r && !timed_out;
        if (timed_out)
          state_next = LSU_DONE;
        else if (dm_ack_i)
          state_next = (!phase2 && crosses_r) ? LSU_ACC2 : LSU_DONE;
      end
      LSU_DONE: begin
        w_valid_o = 1'b1;
        if (fault_r) begin
          x_exception_o       = 1'b1;
          x_exception_cause_o = store_r ? CAUSE_STORE_ACCESS_FAULT : CAUSE_LOAD_ACCESS_FAULT;
          x_badaddr_o         = ea_r;
        end
        if (!x_stall_i)
          state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= LSU_IDLE;
      ea_r           <= '0;
      fun_r          <= '0;
      store_r        <= 1'b0;
      rs2_r          <= '0;
      lo_r           <= '0;
      w_load_value_o <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        ea_r    <= ea;
        fun_r   <= d_fun_i;
        store_r <= d_is_store_i;
        rs2_r   <= d_rs2_i;
      end
      if (ack_ok && !phase2)
        lo_r <= dm_data_l_i;
      if (ack_ok && state_next == LSU_DONE && !store_r)
        w_load_value_o <= ld_value;
    end
  end

`ifdef URV_LSU_BUS_TIMEOUT_EN
  logic [31:0] tmo_cnt;
  logic        fault_q;

  // A limit of zero turns the timeout off.
  assign timed_out = (g_timeout_cycles != 0) && in_acc &&
                     (tmo_cnt == 32'(g_timeout_cycles));
  assign fault_r   = fault_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tmo_cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      if (state_next != state &&
          (state_next == LSU_ACC1 || state_next == LSU_ACC2))
        tmo_cnt <= '0;
      else if (in_acc && !dm_ack_i && !timed_out)
        tmo_cnt <= tmo_cnt + 32'd1;
      if (accept)
        fault_q <= 1'b0;
      else if (timed_out)
        fault_q <= 1'b1;
    end
  end
`else
  // Without the timeout build the limit has no effect: wait for ack forever.
  assign timed_out = 1'b0 & (g_timeout_cycles != 0);
  assign fault_r   = 1'b0;
`endif

endmodule
